sat_addsub_pipe: RTL and testbench



---
 rtl/sat_alu_pkg.sv | 31 +++
 rtl/sat_clamp.sv | 33 +++
 rtl/sat_addsub_pipe.sv | 148 ++++++++++++++
 tb/tb_sat_addsub_pipe.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sat_alu_pkg.sv
// sat_alu_pkg: shared types and helpers for the saturating add/sub pipeline.
//   op_e    - operation encoding presented on the op port
//   flags_t - {zr, neg, ov} describing a result value
//   sat_max / sat_min - most positive / most negative signed value for a width
//                       (returned in MAX_W bits; callers truncate to their width)
package sat_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD    = 2'b00,
    OP_SUB    = 2'b01,
    OP_ACC    = 2'b10,
    OP_CLRACC = 2'b11
  } op_e;

  typedef struct packed {
    logic zr;
    logic neg;
    logic ov;
  } flags_t;

  localparam int unsigned MAX_W = 64;

  function automatic logic [MAX_W-1:0] sat_max(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [MAX_W-1:0] sat_min(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/sat_clamp.sv
// sat_clamp: combinational clamp of a WIDTH+1-bit signed raw result.
//   i_raw   - sign-extended raw sum/difference
//   i_ovf   - signed overflow of that result
//   i_sat   - 1 = clamp to MAX/MIN on overflow, 0 = wrap
//   o_out   - WIDTH-bit result
//   o_flags - {zr, neg, ov} describing o_out
module sat_clamp
  import sat_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH:0]   i_raw,
  input  logic             i_ovf,
  input  logic             i_sat,
  output logic [WIDTH-1:0] o_out,
  output flags_t           o_flags
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(sat_min(WIDTH));

  always_comb begin
    o_out = i_raw[WIDTH-1:0];
    if (i_sat && i_ovf) begin
      // Extra sign bit gives the true direction of the overflow.
      o_out = i_raw[WIDTH] ? MIN_V : MAX_V;
    end
    o_flags.zr  = (o_out == '0);
    o_flags.neg = o_out[WIDTH-1];
    o_flags.ov  = i_ovf;
  end

endmodule

// File: rtl/sat_addsub_pipe.sv
// sat_addsub_pipe: two-stage pipelined signed add / sub / accumulate with
// per-transaction saturate-or-wrap and registered zr/neg/ov flags.
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_ready   - operation handshake (op, sat, in1, in2)
//   out_valid/out_ready - result handshake (out, zr, neg, ov)
// Optional build macro SAT_ADDSUB_STICKY_OV_EN adds sticky_clr / ov_sticky,
// a sticky record of any delivered result with ov set.
module sat_addsub_pipe
  import sat_alu_pkg::*;
#(
  parameter int unsigned      WIDTH    = 16,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SAT_ADDSUB_STICKY_OV_EN
  input  logic             sticky_clr,
  output logic             ov_sticky,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic             sat,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             neg,
  output logic             ov
);

  logic [WIDTH-1:0] r_acc;
  logic             r_s1_valid;
  logic [WIDTH:0]   r_s1_raw;
  op_e              r_s1_op;
  logic             r_s1_sat;

  op_e              w_op;
  logic             w_stall;
  logic             w_accept;
  logic [WIDTH:0]   w_a_x;
  logic [WIDTH:0]   w_b_x;
  logic [WIDTH:0]   w_acc_x;
  logic [WIDTH:0]   w_acc_raw;
  logic [WIDTH:0]   w_raw;
  logic             w_acc_ovf;
  logic [WIDTH-1:0] w_acc_next;
  flags_t           w_acc_flags_unused;
  logic             w_s2_ovf;
  logic [WIDTH-1:0] w_s2_out;
  flags_t           w_s2_flags;

  assign w_op     = op_e'(op);
  assign w_stall  = out_valid & ~out_ready;
  assign in_ready = ~r_s1_valid | ~w_stall;
  assign w_accept = in_valid & in_ready;

  assign w_a_x   = {in1[WIDTH-1], in1};
  assign w_b_x   = {in2[WIDTH-1], in2};
  assign w_acc_x = {r_acc[WIDTH-1], r_acc};

  // Accumulator is clamped at acceptance so back-to-back ACCs chain without a
  // bubble; stage 2 re-clamps the same raw value through an identical clamp.
  // With sign-extended operands, overflow == the top two raw bits disagree.
  assign w_acc_raw = w_acc_x + w_a_x;
  assign w_acc_ovf = w_acc_raw[WIDTH] ^ w_acc_raw[WIDTH-1];

  sat_clamp #(.WIDTH(WIDTH)) u_acc_clamp (
    .i_raw   (w_acc_raw),
    .i_ovf   (w_acc_ovf),
    .i_sat   (sat),
    .o_out   (w_acc_next),
    .o_flags (w_acc_flags_unused)
  );

  always_comb begin
    w_raw = '0;
    case (w_op)
      OP_ADD:  w_raw = w_a_x + w_b_x;
      OP_SUB:  w_raw = w_a_x - w_b_x;
      OP_ACC:  w_raw = w_acc_raw;
      default: w_raw = '0;
    endcase
  end

  assign w_s2_ovf = (r_s1_op != OP_CLRACC) & (r_s1_raw[WIDTH] ^ r_s1_raw[WIDTH-1]);

  sat_clamp #(.WIDTH(WIDTH)) u_s2_clamp (
    .i_raw   (r_s1_raw),
    .i_ovf   (w_s2_ovf),
    .i_sat   (r_s1_sat),
    .o_out   (w_s2_out),
    .o_flags (w_s2_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_raw   <= '0;
      r_s1_op    <= OP_ADD;
      r_s1_sat   <= 1'b0;
      r_acc      <= ACC_INIT;
      out_valid  <= 1'b0;
      out        <= '0;
      zr         <= 1'b0;
      neg        <= 1'b0;
      ov         <= 1'b0;
    end else begin
      if (in_ready) begin
        r_s1_valid <= in_valid;
      end
      if (w_accept) begin
        r_s1_raw <= w_raw;
        r_s1_op  <= w_op;
        r_s1_sat <= sat;
        if (w_op == OP_ACC) begin
          r_acc <= w_acc_next;
        end else if (w_op == OP_CLRACC) begin
          r_acc <= ACC_INIT;
        end
      end
      if (!w_stall) begin
        out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          out <= w_s2_out;
          zr  <= w_s2_flags.zr;
          neg <= w_s2_flags.neg;
          ov  <= w_s2_flags.ov;
        end
      end
    end
  end

`ifdef SAT_ADDSUB_STICKY_OV_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ov_sticky <= 1'b0;
    end else if (out_valid && out_ready && ov) begin
      ov_sticky <= 1'b1;
    end else if (sticky_clr) begin
      ov_sticky <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_sat_addsub_pipe.sv
module tb_sat_addsub_pipe;
  import sat_alu_pkg::*;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic         sat;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         zr;
  logic         neg;
  logic         ov;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sat_addsub_pipe #(.WIDTH(W), .ACC_INIT(16'h0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .sat       (sat),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zr        (zr),
    .neg       (neg),
    .ov        (ov)
  );

  typedef struct {
    logic [1:0]   vop;
    logic         vsat;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [2:0]   flg;  // {zr, neg, ov}
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; op = 2'b00; sat = 1'b0;
    in1 = '0; in2 = '0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tests_run++;
    if ({out_valid, out, zr, neg, ov} !== {1'b0, 16'h0000, 3'b000}) begin
      tests_failed++;
      $display("FAIL reset_outputs: got valid=%b out=%h zno=%b%b%b expected 0 0000 000",
               out_valid, out, zr, neg, ov);
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_vectors();
    vec_t v[11];
    v[0]  = '{2'b00, 1'b1, 16'h7000, 16'h1000, 16'h7FFF, 3'b001};
    v[1]  = '{2'b00, 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 3'b011};
    v[2]  = '{2'b00, 1'b0, 16'h8000, 16'hFFFF, 16'h7FFF, 3'b001};
    v[3]  = '{2'b01, 1'b1, 16'h0005, 16'h0005, 16'h0000, 3'b100};
    v[4]  = '{2'b01, 1'b1, 16'h0000, 16'h8000, 16'h7FFF, 3'b001};
    v[5]  = '{2'b01, 1'b0, 16'h0000, 16'h8000, 16'h8000, 3'b011};
    v[6]  = '{2'b01, 1'b1, 16'h8000, 16'h8000, 16'h0000, 3'b100};
    v[7]  = '{2'b00, 1'b1, 16'h8000, 16'h8000, 16'h8000, 3'b011};
    v[8]  = '{2'b00, 1'b0, 16'h8000, 16'h8000, 16'h0000, 3'b101};
    v[9]  = '{2'b00, 1'b0, 16'h1234, 16'h0001, 16'h1235, 3'b000};
    v[10] = '{2'b01, 1'b1, 16'h0003, 16'h0005, 16'hFFFE, 3'b010};
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1; op = v[i].vop; sat = v[i].vsat; in1 = v[i].a; in2 = v[i].b;
      tick();
      in_valid = 1'b0;
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL vec%0d_early_valid: got %b expected 0", i, out_valid);
      end
      tick();
      tests_run++;
      if ({out_valid, out, zr, neg, ov} !== {1'b1, v[i].res, v[i].flg}) begin
        tests_failed++;
        $display("FAIL vec%0d_result: got valid=%b out=%h zno=%b%b%b expected 1 %h %b",
                 i, out_valid, out, zr, neg, ov, v[i].res, v[i].flg);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back_acc();
    logic [W-1:0] eo[4];
    logic [2:0]   ef[4];
    int k = 0;
    eo = '{16'h0000, 16'h4000, 16'h7FFF, 16'h7FFF};
    ef = '{3'b100, 3'b000, 3'b001, 3'b001};
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c < 4) begin
        in_valid = 1'b1; op = (c == 0) ? 2'b11 : 2'b10; sat = 1'b1;
        in1 = 16'h4000; in2 = 16'h1111;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (out_valid) begin
        tests_run++;
        if (k >= 4) begin
          tests_failed++;
          $display("FAIL acc_extra_result: got out=%h with %0d already seen expected none", out, k);
        end else if ({out, zr, neg, ov} !== {eo[k], ef[k]}) begin
          tests_failed++;
          $display("FAIL acc_result%0d: got out=%h zno=%b%b%b expected %h %b",
                   k, out, zr, neg, ov, eo[k], ef[k]);
        end
        k++;
      end
    end
    tests_run++;
    if (k != 4) begin
      tests_failed++;
      $display("FAIL acc_count: got %0d results expected 4", k);
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] sa[4];
    int idx = 0;
    int k = 0;
    logic acc_now, take_now;
    logic [W-1:0] seen;
    sa = '{16'h0001, 16'h0011, 16'h0021, 16'h0031};
    op = 2'b00; sat = 1'b1; in2 = 16'h0100;
    for (int c = 0; c < 30; c++) begin
      out_ready = (c >= 6);
      in_valid  = (idx < 4);
      in1       = sa[(idx < 4) ? idx : 3];
      #1;
      acc_now  = in_valid & in_ready;
      take_now = out_valid & out_ready;
      seen     = out;
      if (c >= 2 && c < 6) begin
        tests_run++;
        if ({out_valid, in_ready, out} !== {1'b1, 1'b0, 16'h0101}) begin
          tests_failed++;
          $display("FAIL stall_hold_c%0d: got valid=%b in_ready=%b out=%h expected 1 0 0101",
                   c, out_valid, in_ready, out);
        end
      end
      if (c == 5) begin
        tests_run++;
        if (idx != 2) begin
          tests_failed++;
          $display("FAIL stall_accepted: got %0d expected 2", idx);
        end
      end
      @(posedge clk);
      #1;
      if (acc_now) idx++;
      if (take_now) begin
        tests_run++;
        if (k >= 4) begin
          tests_failed++;
          $display("FAIL stall_dup: got extra out=%h expected none", seen);
        end else if (seen !== sa[k] + 16'h0100) begin
          tests_failed++;
          $display("FAIL stall_order%0d: got %h expected %h", k, seen, sa[k] + 16'h0100);
        end
        k++;
      end
    end
    in_valid = 1'b0;
    tests_run++;
    if (k != 4 || idx != 4) begin
      tests_failed++;
      $display("FAIL stall_totals: got out=%0d in=%0d expected 4 4", k, idx);
    end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1; sat = 1'b1; op = 2'b00;
    in_valid = 1'b1; in1 = 16'h0001; in2 = 16'h0001;
    tick();
    in1 = 16'h0002; in2 = 16'h0002;
    tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if ({out_valid, out, zr, neg, ov} !== {1'b0, 16'h0000, 3'b000}) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got valid=%b out=%h zno=%b%b%b expected 0 0000 000",
               out_valid, out, zr, neg, ov);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL midreset_leak%0d: got valid=%b out=%h expected valid 0", c, out_valid, out);
      end
    end
    in_valid = 1'b1; op = 2'b10; in1 = 16'h0001; in2 = 16'h0000;
    tick();
    in_valid = 1'b0;
    tick();
    tests_run++;
    if ({out_valid, out, zr, neg, ov} !== {1'b1, 16'h0001, 3'b000}) begin
      tests_failed++;
      $display("FAIL midreset_acc: got valid=%b out=%h zno=%b%b%b expected 1 0001 000",
               out_valid, out, zr, neg, ov);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back_acc();
    test_stall();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
